// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, branch/jump resolution
// and a two-cycle front-end flush after every taken control transfer.
// All state updates on the falling edge of clk; rst_n is asynchronous.
// Optional feature: define TAKEN_CNT_EN to add a 16-bit taken-transfer counter.
module exmem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        RegWrtIn,
    input  logic        memToRegIn,
    input  logic        PCtoRegIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic        BranchNIn,
    input  logic        BranchZIn,
    input  logic        JumpIn,
    input  logic        JumpMemIn,
    input  logic [31:0] aluResIn,
    input  logic        aluNIn,
    input  logic        aluZIn,
    input  logic [31:0] XrtIn,
    input  logic [31:0] PC_YIn,
    input  logic [5:0]  rdIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        RegWrtOut,
    output logic        memToRegOut,
    output logic        PCtoRegOut,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic [31:0] aluResOut,
    output logic [31:0] XrtOut,
    output logic [5:0]  rdOut,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
`ifdef TAKEN_CNT_EN
    output logic [15:0] taken_cnt,
`endif
    output logic        flush
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 6;
    localparam int unsigned CTW  = 5;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            flush_cnt_q, flush_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            pc_redirect_q, pc_redirect_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] pc_target_q, pc_target_d;

    logic [CTW-1:0]  ctrl_q;
    logic [XLEN-1:0] alu_res_q;
    logic [XLEN-1:0] xrt_q;
    logic [RW-1:0]   rd_q;

    logic accept_c;
    logic consume_c;
    logic taken_c;

    // Handshake: accept only from EMPTY, or from FULL when the slot drains this edge
    assign in_ready  = (state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready);
    assign accept_c  = in_valid & in_ready;
    assign consume_c = out_valid_q & out_ready;
    assign taken_c   = accept_c & (JumpIn | JumpMemIn | (BranchNIn & aluNIn) | (BranchZIn & aluZIn));

    // Next-state, valid tracking, redirect and flush sequencing
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        out_valid_d   = out_valid_q;
        pc_redirect_d = 1'b0;
        pc_target_d   = pc_target_q;

        if (accept_c) begin
            out_valid_d = 1'b1;
        end else if (consume_c) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_EMPTY, S_FULL: begin
                if (taken_c) begin
                    state_d       = S_FLUSH;
                    flush_cnt_d   = 1'b0;
                    pc_redirect_d = 1'b1;
                    pc_target_d   = JumpMemIn ? aluResIn : PC_YIn;
                end else if (accept_c) begin
                    state_d = S_FULL;
                end else if (consume_c) begin
                    state_d = S_EMPTY;
                end
            end
            S_FLUSH: begin
                // Second flush cycle ends the window; the slot may have drained meanwhile
                if (flush_cnt_q) begin
                    flush_cnt_d = 1'b0;
                    state_d     = out_valid_d ? S_FULL : S_EMPTY;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_EMPTY;
                flush_cnt_d = 1'b0;
            end
        endcase

        flush_d = (state_d == S_FLUSH);
    end

    // Control state register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_EMPTY;
            flush_cnt_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            pc_redirect_q <= 1'b0;
            flush_q       <= 1'b0;
            pc_target_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            out_valid_q   <= out_valid_d;
            pc_redirect_q <= pc_redirect_d;
            flush_q       <= flush_d;
            pc_target_q   <= pc_target_d;
        end
    end

    // Payload register: loads only on accept, otherwise holds
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            alu_res_q <= '0;
            xrt_q     <= '0;
            rd_q      <= '0;
        end else if (accept_c) begin
            ctrl_q    <= {RegWrtIn, memToRegIn, PCtoRegIn, memReadIn, memWriteIn};
            alu_res_q <= aluResIn;
            xrt_q     <= XrtIn;
            rd_q      <= rdIn;
        end
    end

`ifdef TAKEN_CNT_EN
    localparam int unsigned CNTW = 16;
    logic [CNTW-1:0] taken_cnt_q;

    // Count taken transfers, wrapping at the counter width
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else if (taken_c) begin
            taken_cnt_q <= taken_cnt_q + CNTW'(1);
        end
    end

    assign taken_cnt = taken_cnt_q;
`endif

    assign out_valid   = out_valid_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;
    assign flush       = flush_q;
    assign {RegWrtOut, memToRegOut, PCtoRegOut, memReadOut, memWriteOut} = ctrl_q;
    assign aluResOut   = alu_res_q;
    assign XrtOut      = xrt_q;
    assign rdOut       = rd_q;

endmodule
